// File: rtl/spy_uart_rx_pkg.sv
// spy_uart_rx_pkg
//   Shared definitions for the spy port serial receiver: receiver state
//   encoding, the default bit period for the 25 MHz / 50 MHz spy clock
//   builds, the counter width and a 3-input majority helper.
package spy_uart_rx_pkg;

  // Receiver states (3-bit encoding is shared with the decoder side).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Clock cycles per bit at 115200 baud for the selected spy clock build.
`ifdef clk_50mhz
  localparam int unsigned DEFAULT_BIT_CYCLES = 434;
`else
  localparam int unsigned DEFAULT_BIT_CYCLES = 217;
`endif

  // Wide enough for the largest legal bit period (4095).
  localparam int unsigned CNT_W = 12;

  // Two-out-of-three vote over the sample history.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/spy_uart_rx_sync.sv
// spy_uart_rx_sync
//   Brings the asynchronous serial line into the clk domain and produces a
//   glitch-filtered sample.
//   Ports:
//     clk    in   spy clock
//     reset  in   asynchronous active-high reset
//     rxd_i  in   raw serial line (idle high)
//     s_o    out  synchronized line, rxd_i delayed two cycles
//     maj_o  out  majority vote of the last three synchronized samples
module spy_uart_rx_sync
  import spy_uart_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rxd_i,
  output logic s_o,
  output logic maj_o
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Everything resets to the idle (high) line level so no false start is
  // seen coming out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign s_o   = sync_q[1];
  assign maj_o = majority3(hist_q);

endmodule

// File: rtl/spy_uart_rx.sv
// spy_uart_rx
//   8N1 serial receiver feeding the spy port command decoder. Bytes are
//   handed over through a req/ack holding register.
//   Ports:
//     clk             in   spy clock
//     reset           in   asynchronous active-high reset
//     rs232_rxd       in   raw serial input, idle high, asynchronous
//     rx_data         out  received byte, valid while ld_rx_req=1
//     ld_rx_req       out  holding register full
//     ld_rx_ack       in   consumer takes the byte (only while ld_rx_req=1)
//     rx_framing_err  out  one-cycle pulse when the stop bit samples 0
//     rx_overrun      out  sticky: a byte was dropped, holding register full
//     clr_err         in   clears rx_overrun
//     rx_busy         out  receiver is not idle
module spy_uart_rx
  import spy_uart_rx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = DEFAULT_BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs232_rxd,
  output logic [7:0] rx_data,
  output logic       ld_rx_req,
  input  logic       ld_rx_ack,
  output logic       rx_framing_err,
  output logic       rx_overrun,
  input  logic       clr_err,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  logic             s;
  logic             maj;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             req_q;
  logic             ferr_q;
  logic             ovr_q;

  spy_uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd_i (rs232_rxd),
    .s_o   (s),
    .maj_o (maj)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      req_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      // Consumer handshake and error clear; a delivery or overrun below is
      // assigned later in this block and therefore takes priority.
      if (req_q && ld_rx_ack) req_q <= 1'b0;
      if (clr_err)            ovr_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end

        ST_START: begin
          // Re-check the line at the start-bit centre; a high vote means
          // the falling edge was only a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= maj ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {maj, shift_q[7:1]};  // LSB arrives first
            if (idx_q == 3'd7) state_q <= ST_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (maj) begin
              state_q <= ST_IDLE;
              // An ack in this same cycle frees the register for the new byte.
              if (!req_q || ld_rx_ack) begin
                rx_data_q <= shift_q;
                req_q     <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_WAIT_IDLE: begin
          // Hold off until the line is released so a break cannot retrigger.
          if (s) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data        = rx_data_q;
  assign ld_rx_req      = req_q;
  assign rx_framing_err = ferr_q;
  assign rx_overrun     = ovr_q;
  assign rx_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spy_uart_rx.sv
// tb_spy_uart_rx
//   Directed bench for spy_uart_rx at the default 217-cycle bit period.
//   Expected bytes are queued as frames are sent; bytes taken by the
//   consumer are captured and compared against that queue.
module tb_spy_uart_rx;

  localparam int BIT = 217;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rs232_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       ld_rx_req;
  logic       ld_rx_ack;
  logic       rx_framing_err;
  logic       rx_overrun;
  logic       clr_err = 1'b0;
  logic       rx_busy;

  spy_uart_rx dut (
    .clk            (clk),
    .reset          (reset),
    .rs232_rxd      (rs232_rxd),
    .rx_data        (rx_data),
    .ld_rx_req      (ld_rx_req),
    .ld_rx_ack      (ld_rx_ack),
    .rx_framing_err (rx_framing_err),
    .rx_overrun     (rx_overrun),
    .clr_err        (clr_err),
    .rx_busy        (rx_busy)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_mem [0:63];
  int         got_count = 0;   // written only by the consumer process
  int         rd_idx = 0;      // written only by the main sequence

  // Consumer controls (written by the main sequence)
  bit auto_ack = 1'b0;
  bit ack_now  = 1'b0;

  // Monitor counters (written only by the monitor)
  int  req_rises = 0;
  int  ferr_cycles = 0;
  logic req_prev = 1'b0;

  // Consumer: acks either on request or three cycles after req, and
  // captures the byte it takes.
  initial begin : consumer
    int age;
    age = 0;
    ld_rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ld_rx_ack) begin
        ld_rx_ack = 1'b0;
        age = 0;
      end else if (ld_rx_req && (ack_now || (auto_ack && age >= 2))) begin
        ld_rx_ack = 1'b1;
        got_mem[got_count[5:0]] = rx_data;
        got_count = got_count + 1;
        age = 0;
      end else if (ld_rx_req && auto_ack) begin
        age = age + 1;
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: counts req rising edges and framing-error cycles.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (ld_rx_req && !req_prev) req_rises = req_rises + 1;
      req_prev = ld_rx_req;
      if (rx_framing_err) ferr_cycles = ferr_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_bits(input int n);
    rs232_rxd = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rs232_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rs232_rxd = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  // Compare every captured byte against the expected queue.
  task automatic check_sb();
    logic [7:0] e;
    @(posedge clk);
    #1;
    while (rd_idx < got_count) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", {24'd0, got_mem[rd_idx[5:0]]}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", {24'd0, got_mem[rd_idx[5:0]]}, {24'd0, e});
      end
      $display("tb: byte %0d taken 0x%02h", rd_idx, got_mem[rd_idx[5:0]]);
      rd_idx = rd_idx + 1;
    end
    @(negedge clk);
  endtask

  // Manual ack, bounded wait; req must be low right after the ack edge.
  task automatic manual_ack(input string tag);
    int n;
    int target;
    target = got_count + 1;
    ack_now = 1'b1;
    n = 0;
    while (got_count < target && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_ack_taken"}, (got_count >= target) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, "_req_drop"}, {31'd0, ld_rx_req}, 32'd0);
    ack_now = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int rises0;
    logic [7:0] seq [6];
    seq = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_req", {31'd0, ld_rx_req}, 32'd0);
    chk("rst_ferr", {31'd0, rx_framing_err}, 32'd0);
    chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    idle_bits(1);

    // 0x82: exact req latency, then manual ack
    auto_ack = 1'b0;
    exp_q.push_back(8'h82);
    rs232_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = (8'h82 >> i) & 8'h01 ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rs232_rxd = 1'b1;
    repeat (110) @(negedge clk);
    chk("b82_req_before", {31'd0, ld_rx_req}, 32'd0);
    @(negedge clk);
    chk("b82_req_at_2062", {31'd0, ld_rx_req}, 32'd1);
    chk("b82_data", {24'd0, rx_data}, 32'h82);
    repeat (BIT - 111) @(negedge clk);
    manual_ack("b82");
    check_sb();
    chk("b82_no_ferr", ferr_cycles, 32'd0);
    chk("b82_req_rises", req_rises, 32'd1);
    $display("tb: single byte 0x82 done");

    // Back-to-back sequence with auto ack
    auto_ack = 1'b1;
    foreach (seq[k]) begin
      exp_q.push_back(seq[k]);
      send_byte(seq[k], 1'b1);
    end
    idle_bits(1);
    check_sb();
    chk("seq_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("seq_pending", exp_q.size(), 32'd0);
    chk("seq_req_rises", req_rises, 32'd7);
    $display("tb: back-to-back sequence done");

    // 3-cycle glitch: false start rejected at t0+108
    rs232_rxd = 1'b0;
    repeat (3) @(negedge clk);
    rs232_rxd = 1'b1;
    repeat (107) @(negedge clk);
    chk("glitch_busy_start", {31'd0, rx_busy}, 32'd1);
    @(negedge clk);
    chk("glitch_busy_idle", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);
    chk("glitch_no_req", req_rises, 32'd7);
    chk("glitch_no_ferr", ferr_cycles, 32'd0);
    $display("tb: glitch rejected");

    // Framing error followed by a 30-bit break, then a good byte
    rs232_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = (8'h55 >> i) & 8'h01 ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rs232_rxd = 1'b0;
    repeat (31 * BIT) @(negedge clk);
    chk("brk_busy_held", {31'd0, rx_busy}, 32'd1);
    chk("brk_ferr_one_pulse", ferr_cycles, 32'd1);
    chk("brk_no_req", req_rises, 32'd7);
    rs232_rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("brk_busy_released", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    idle_bits(1);
    check_sb();
    chk("brk_after_pending", exp_q.size(), 32'd0);
    $display("tb: framing error and recovery done");

    // Overrun: two bytes without ack
    auto_ack = 1'b0;
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle_bits(1);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h01);
    chk("ovr_req", {31'd0, ld_rx_req}, 32'd1);
    chk("ovr_set", {31'd0, rx_overrun}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_cleared", {31'd0, rx_overrun}, 32'd0);
    chk("ovr_data_after_clr", {24'd0, rx_data}, 32'h01);
    manual_ack("ovr");
    check_sb();
    $display("tb: overrun and clear done");

    // Reset mid-frame during data bit 4 of 0x80
    auto_ack = 1'b1;
    rises0 = req_rises;
    rs232_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rxd = (8'h80 >> i) & 8'h01 ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rs232_rxd = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_req", {31'd0, ld_rx_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("mid_rst_ovr", {31'd0, rx_overrun}, 32'd0);
    @(negedge clk);
    rs232_rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_bits(2);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    check_sb();
    chk("mid_one_delivery", req_rises - rises0, 32'd1);
    chk("final_pending", exp_q.size(), 32'd0);
    chk("final_taken", got_count, 32'd10);
    $display("tb: reset mid-frame done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
